// File: rtl/bin_to_seg_converter_pkg.sv
// Shared types and constants for the binary to seven-segment converter:
// FSM states, segment patterns and the double-dabble nibble correction.
package bin_to_seg_converter_pkg;

  localparam int VALUE_W    = 14;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SEG_W      = 7;
  localparam int ITERATIONS = VALUE_W;
  localparam int ITER_W     = $clog2(ITERATIONS);

  localparam logic [ITER_W-1:0]  ITER_LAST = ITER_W'(ITERATIONS - 1);
  localparam logic [VALUE_W-1:0] MAX_VALUE = VALUE_W'(9999);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Add 3 to every BCD nibble >= 5 so the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin_to_seg_converter_seven_seg_decoder.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes stay dark.
module seven_seg_decoder
  import bin_to_seg_converter_pkg::*;
(
  input  logic [3:0]       i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here via the default arm); a missed path would infer a latch.
    unique case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_seg_converter.sv
// Binary to 4-digit seven-segment converter: serial double-dabble over 14
// cycles, then one registered update of indicators, enable and overflow.
module bin_to_seg_converter
  import bin_to_seg_converter_pkg::*;
#(
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [SEG_W-1:0]      indicator0,
  output logic [SEG_W-1:0]      indicator1,
  output logic [SEG_W-1:0]      indicator2,
  output logic [SEG_W-1:0]      indicator3,
  output logic [NUM_DIGITS-1:0] enable
);

  localparam int SHIFT_W = BCD_W + VALUE_W;

  state_t                           r_state;
  state_t                           w_next_state;
  logic [ITER_W-1:0]                r_iter;
  logic [SHIFT_W-1:0]               r_shift;
  logic [SHIFT_W-1:0]               w_adjusted;
  logic [SHIFT_W-1:0]               w_shifted;
  logic                             r_value_ovf;
  logic [NUM_DIGITS-1:0][3:0]       w_digit;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] w_seg;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] r_indicator;
  logic [NUM_DIGITS-1:0]            w_enable;
  logic [NUM_DIGITS-1:0]            r_enable;
  logic                             w_seen_nonzero;
  logic                             r_done;
  logic                             r_overflow;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (r_iter == ITER_LAST) w_next_state = UPDATE;
      UPDATE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ------------------------------------------------------ double dabble
  // BCD and binary share one register so each iteration is a single shift.
  assign w_adjusted = {bcd_adjust(r_shift[VALUE_W +: BCD_W]), r_shift[VALUE_W-1:0]};
  assign w_shifted  = w_adjusted << 1;
  assign w_digit    = r_shift[VALUE_W +: BCD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_iter      <= '0;
      r_value_ovf <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift     <= {{BCD_W{1'b0}}, value};
            r_iter      <= '0;
            r_value_ovf <= (value > MAX_VALUE);
          end
        end
        SHIFT: begin
          r_shift <= w_shifted;
          r_iter  <= r_iter + ITER_W'(1);
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------- display formation
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
    seven_seg_decoder u_dec (
      .i_bcd (w_digit[gi]),
      .o_seg (w_seg[gi])
    );
  end

  // A digit stays enabled once it or any more significant digit is non-zero;
  // the units digit is always shown so zero still displays as "0".
  always_comb begin
    w_enable       = '1;
    w_seen_nonzero = 1'b0;
    if (BLANK_LEADING != 0) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        w_seen_nonzero = w_seen_nonzero | (w_digit[i] != 4'd0);
        w_enable[i]    = w_seen_nonzero;
      end
    end
  end

  // Outputs only move in UPDATE, so partial BCD never reaches the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_indicator <= '0;
      r_enable    <= '0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == UPDATE);
      if (r_state == UPDATE) begin
        if (r_value_ovf) begin
          r_indicator <= {NUM_DIGITS{SEG_DASH}};
          r_enable    <= '1;
          r_overflow  <= 1'b1;
        end else begin
          r_indicator <= w_seg;
          r_enable    <= w_enable;
          r_overflow  <= 1'b0;
        end
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign indicator0 = r_indicator[0];
  assign indicator1 = r_indicator[1];
  assign indicator2 = r_indicator[2];
  assign indicator3 = r_indicator[3];
  assign enable     = r_enable;

endmodule
